// File: rtl/object_render_scheduler.sv
// object_render_scheduler
//   Per-pixel sequencer and arbiter for the shared object sprite ROM port.
//   Holds position/enable registers for NUM_SLOTS object slots, tests which
//   slots cover a requested pixel, issues one ROM read per covering slot in
//   priority order (slot 0 first) and returns the first opaque color, or the
//   background color, as a one-cycle pixel_valid pulse.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   cfg_we/slot/x/y/en      slot register write
//   pixel_start, pix_x/y    request to composite one pixel (accepted in IDLE)
//   bg_color                color used when no covering object is opaque
//   busy                    scan in progress; new requests are dropped
//   pixel_valid, rgb_out    result pulse and held result color
//   overrun                 sticky: a request arrived while busy
//   rom_row/col/index       ROM read request (index 0 = no read)
//   rom_data                ROM color, one cycle after the read

// One hit-test lane: 11-bit compares so x+OBJ_W never wraps past 1023.
module obj_hit_lane #(
  parameter int OBJ_W = 32,
  parameter int OBJ_H = 32
) (
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       en,
  output logic       hit,
  output logic [9:0] row,
  output logic [9:0] col
);
  logic [10:0] px_e, py_e, x_e, y_e;
  assign px_e = {1'b0, px};
  assign py_e = {1'b0, py};
  assign x_e  = {1'b0, x};
  assign y_e  = {1'b0, y};
  assign hit  = en && (px_e >= x_e) && (px_e < x_e + 11'(OBJ_W))
                   && (py_e >= y_e) && (py_e < y_e + 11'(OBJ_H));
  assign row  = py - y;
  assign col  = px - x;
endmodule

module object_render_scheduler #(
  parameter int          NUM_SLOTS   = 4,
  parameter int          OBJ_W       = 32,
  parameter int          OBJ_H       = 32,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_slot,
  input  logic [9:0]  cfg_x,
  input  logic [9:0]  cfg_y,
  input  logic        cfg_en,
  input  logic        pixel_start,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [11:0] bg_color,
  output logic        busy,
  output logic        pixel_valid,
  output logic [11:0] rgb_out,
  output logic        overrun,
  output logic [9:0]  rom_row,
  output logic [9:0]  rom_col,
  output logic [2:0]  rom_index,
  input  logic [11:0] rom_data
);
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [SW-1:0] LAST = SW'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                        state;
  logic [SW-1:0]                 slot, nxt;
  logic                          pending;   // a read was issued last cycle
  logic [NUM_SLOTS-1:0][9:0]     cur_x, cur_y, snap_x, snap_y, lane_x, lane_y;
  logic [NUM_SLOTS-1:0]          cur_en, snap_en, lane_en, lane_hit;
  logic [NUM_SLOTS-1:0][9:0]     lane_row, lane_col;
  logic [9:0]                    px_r, py_r, lane_px, lane_py;
  logic                          opaque;

  assign busy = (state != S_IDLE);

  // In IDLE the lanes see the live request and live slot registers, so the
  // slot-0 read can be registered on the accept edge itself; during a scan
  // they see the latched pixel and the snapshot.
  assign lane_px = busy ? px_r    : pix_x;
  assign lane_py = busy ? py_r    : pix_y;
  assign lane_x  = busy ? snap_x  : cur_x;
  assign lane_y  = busy ? snap_y  : cur_y;
  assign lane_en = busy ? snap_en : cur_en;

  // Slot whose read is registered at the coming edge.
  assign nxt    = (state == S_ISSUE) ? slot + SW'(1) : '0;
  assign opaque = pending && (rom_data != TRANSPARENT);

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_lane
      obj_hit_lane #(.OBJ_W(OBJ_W), .OBJ_H(OBJ_H)) u_lane (
        .px (lane_px),     .py (lane_py),
        .x  (lane_x[i]),   .y  (lane_y[i]),   .en (lane_en[i]),
        .hit(lane_hit[i]), .row(lane_row[i]), .col(lane_col[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      slot        <= '0;
      pending     <= 1'b0;
      cur_x       <= '0;
      cur_y       <= '0;
      cur_en      <= '0;
      snap_x      <= '0;
      snap_y      <= '0;
      snap_en     <= '0;
      px_r        <= '0;
      py_r        <= '0;
      pixel_valid <= 1'b0;
      rgb_out     <= '0;
      overrun     <= 1'b0;
      rom_index   <= '0;
      rom_row     <= '0;
      rom_col     <= '0;
    end else begin
      if (cfg_we) begin
        cur_x[cfg_slot]  <= cfg_x;
        cur_y[cfg_slot]  <= cfg_y;
        cur_en[cfg_slot] <= cfg_en;
      end
      if (pixel_start && busy) overrun <= 1'b1;
      pixel_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pixel_start) begin
            px_r      <= pix_x;
            py_r      <= pix_y;
            snap_x    <= cur_x;
            snap_y    <= cur_y;
            snap_en   <= cur_en;
            slot      <= '0;
            pending   <= 1'b0;
            state     <= S_ISSUE;
            rom_index <= lane_hit[nxt] ? 3'(nxt) + 3'd1 : 3'd0;
            rom_row   <= lane_hit[nxt] ? lane_row[nxt] : 10'd0;
            rom_col   <= lane_hit[nxt] ? lane_col[nxt] : 10'd0;
          end
        end
        S_ISSUE: begin
          if (opaque) begin
            // Winner found: the read issued this cycle is abandoned.
            rgb_out     <= rom_data;
            pixel_valid <= 1'b1;
            pending     <= 1'b0;
            state       <= S_DONE;
            rom_index   <= '0;
            rom_row     <= '0;
            rom_col     <= '0;
          end else begin
            pending <= (rom_index != 3'd0);
            if (slot == LAST) begin
              state     <= S_WAIT;
              rom_index <= '0;
              rom_row   <= '0;
              rom_col   <= '0;
            end else begin
              slot      <= nxt;
              rom_index <= lane_hit[nxt] ? 3'(nxt) + 3'd1 : 3'd0;
              rom_row   <= lane_hit[nxt] ? lane_row[nxt] : 10'd0;
              rom_col   <= lane_hit[nxt] ? lane_col[nxt] : 10'd0;
            end
          end
        end
        S_WAIT: begin
          rgb_out     <= opaque ? rom_data : bg_color;
          pixel_valid <= 1'b1;
          pending     <= 1'b0;
          state       <= S_DONE;
        end
        default: state <= S_IDLE;  // S_DONE
      endcase
    end
  end
endmodule

// File: tb/tb_object_render_scheduler.sv
module tb_object_render_scheduler;
  localparam int N = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cfg_we = 1'b0, cfg_en = 1'b0, pixel_start = 1'b0;
  logic [1:0]  cfg_slot = '0;
  logic [9:0]  cfg_x = '0, cfg_y = '0, pix_x = '0, pix_y = '0;
  logic [11:0] bg_color = 12'h123;
  logic        busy, pixel_valid, overrun;
  logic [11:0] rgb_out, rom_data;
  logic [9:0]  rom_row, rom_col;
  logic [2:0]  rom_index;

  always #5 clk = ~clk;

  object_render_scheduler dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_slot(cfg_slot),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en),
    .pixel_start(pixel_start), .pix_x(pix_x), .pix_y(pix_y),
    .bg_color(bg_color), .busy(busy), .pixel_valid(pixel_valid),
    .rgb_out(rgb_out), .overrun(overrun), .rom_row(rom_row),
    .rom_col(rom_col), .rom_index(rom_index), .rom_data(rom_data)
  );

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ROM: one color per sprite index, returned one cycle after the read.
  logic [11:0] rom_tbl [0:7];
  always @(posedge clk or posedge reset)
    if (reset) rom_data <= '0;
    else       rom_data <= (rom_index == 3'd0) ? 12'h555 : rom_tbl[rom_index];

  // Behavioural model: on accept, work out the whole schedule of reads, the
  // completion cycle and the result color from the coverage/priority rules.
  int          m_x [N], m_y [N];
  bit          m_en [N];
  bit          m_busy, m_ovr;
  int          m_cyc, m_done;
  logic [11:0] m_rgb, m_win;
  int          t_idx [1:8], t_row [1:8], t_col [1:8];

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int s = 0; s < N; s++) begin m_x[s] = 0; m_y[s] = 0; m_en[s] = 0; end
      m_busy = 0; m_ovr = 0; m_cyc = 0; m_done = 0; m_rgb = '0;
    end else begin
      if (m_busy) begin
        if (pixel_start) m_ovr = 1;
        if (m_cyc == m_done) m_busy = 0; else m_cyc++;
      end else if (pixel_start) begin
        int px, py; bit found;
        px = int'(pix_x); py = int'(pix_y);
        for (int c = 1; c <= 8; c++) begin t_idx[c] = 0; t_row[c] = 0; t_col[c] = 0; end
        m_done = N + 2; m_win = bg_color; found = 0;
        for (int s = 0; s < N; s++) begin
          // Slot s is read in cycle s+1, unless the scan already ended.
          if (s + 1 <= m_done - 1 && m_en[s] && px >= m_x[s] && px < m_x[s] + 32
              && py >= m_y[s] && py < m_y[s] + 32) begin
            t_idx[s+1] = s + 1; t_row[s+1] = py - m_y[s]; t_col[s+1] = px - m_x[s];
            if (!found && rom_tbl[s+1] != 12'hF0F) begin
              found = 1; m_done = s + 3; m_win = rom_tbl[s+1];
            end
          end
        end
        m_busy = 1; m_cyc = 1;
      end
      if (m_busy && m_cyc == m_done) m_rgb = m_win;
      if (cfg_we) begin
        m_x[cfg_slot] = int'(cfg_x); m_y[cfg_slot] = int'(cfg_y); m_en[cfg_slot] = cfg_en;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      int ei, er, ec; bit epv;
      ei = 0; er = 0; ec = 0;
      if (m_busy && m_cyc <= 8) begin ei = t_idx[m_cyc]; er = t_row[m_cyc]; ec = t_col[m_cyc]; end
      epv = m_busy && (m_cyc == m_done);
      check("cycle", {busy, pixel_valid, rom_index, rom_row, rom_col, rgb_out, overrun},
            {m_busy, epv, 3'(ei), 10'(er), 10'(ec), m_rgb, m_ovr});
    end
  end

  logic [2:0] s_idx [1:8];
  logic [9:0] s_row [1:8], s_col [1:8];

  task automatic cfg(input int slot, input int x, input int y, input bit en);
    cfg_we = 1; cfg_slot = 2'(slot); cfg_x = 10'(x); cfg_y = 10'(y); cfg_en = en;
    @(negedge clk);
    cfg_we = 0;
  endtask

  // Requests one pixel, records the read trace and checks completion cycle
  // and color. dis0_mid disables slot 0 during cycle 1 of the scan.
  task automatic pixel(input string name, input int x, input int y, input int exp_done,
                       input logic [11:0] exp_rgb, input bit dis0_mid);
    int cyc; bit got;
    pix_x = 10'(x); pix_y = 10'(y); pixel_start = 1;
    @(negedge clk);
    pixel_start = 0;
    for (int c = 1; c <= 8; c++) begin s_idx[c] = '0; s_row[c] = '0; s_col[c] = '0; end
    cyc = 1; got = 0;
    while (!got && cyc <= 12) begin
      if (cyc <= 8) begin s_idx[cyc] = rom_index; s_row[cyc] = rom_row; s_col[cyc] = rom_col; end
      if (pixel_valid) got = 1;
      else begin
        if (dis0_mid && cyc == 1) begin
          cfg_we = 1; cfg_slot = 2'd0; cfg_x = 10'd96; cfg_y = 10'd96; cfg_en = 0;
        end else cfg_we = 0;
        @(negedge clk);
        cyc++;
      end
    end
    cfg_we = 0;
    check({name, " done_cycle"}, 64'(cyc), 64'(exp_done));
    check({name, " rgb"}, 64'(rgb_out), 64'(exp_rgb));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) rom_tbl[i] = 12'h000;
    @(negedge clk);
    check("reset_state", {busy, pixel_valid, rom_index, rom_row, rom_col, rgb_out, overrun}, 64'd0);
    @(negedge clk);
    #1 reset = 0;

    // No objects enabled: background after 6 cycles, no reads.
    pixel("noobj", 100, 100, 6, 12'h123, 0);
    check("noobj idx", {s_idx[1], s_idx[2], s_idx[3], s_idx[4], s_idx[5]}, 64'd0);

    // Slot 0 opaque.
    rom_tbl[1] = 12'hABC;
    cfg(0, 96, 96, 1);
    pixel("slot0", 100, 105, 3, 12'hABC, 0);
    check("slot0 idx", 64'(s_idx[1]), 64'd1);
    check("slot0 row", 64'(s_row[1]), 64'd9);
    check("slot0 col", 64'(s_col[1]), 64'd4);

    // Slot 0 transparent, slot 2 opaque at the same pixel.
    rom_tbl[1] = 12'hF0F; rom_tbl[3] = 12'h0F0;
    cfg(2, 96, 96, 1);
    pixel("overlap", 100, 105, 5, 12'h0F0, 0);
    check("overlap idx", {s_idx[1], s_idx[2], s_idx[3]}, {3'd1, 3'd0, 3'd3});

    // Boundaries on slot 1 at (608,448).
    cfg(0, 96, 96, 0);
    cfg(2, 96, 96, 0);
    rom_tbl[2] = 12'h0AA;
    cfg(1, 608, 448, 1);
    pixel("corner", 639, 479, 4, 12'h0AA, 0);
    check("corner read", {s_idx[2], s_row[2], s_col[2]}, {3'd2, 10'd31, 10'd31});
    pixel("right_miss", 640, 448, 6, 12'h123, 0);
    pixel("top_miss", 608, 447, 6, 12'h123, 0);

    // Slot near the right edge: no 10-bit wrap of x+OBJ_W.
    cfg(1, 608, 448, 0);
    rom_tbl[4] = 12'h0DD;
    cfg(3, 1000, 0, 1);
    pixel("edge", 1023, 5, 6, 12'h0DD, 0);
    check("edge read", {s_idx[4], s_row[4], s_col[4]}, {3'd4, 10'd5, 10'd23});
    rom_tbl[4] = 12'hF0F;
    pixel("edge_transp", 1023, 5, 6, 12'h123, 0);
    cfg(3, 1000, 0, 0);

    // Config write mid-scan affects only the next pixel.
    rom_tbl[1] = 12'hABC;
    cfg(0, 96, 96, 1);
    pixel("cfgmid", 100, 105, 3, 12'hABC, 1);
    pixel("cfgafter", 100, 105, 6, 12'h123, 0);

    // Request during a scan is dropped and sets the sticky overrun.
    check("ovr_before", 64'(overrun), 64'd0);
    pix_x = 10'd200; pix_y = 10'd200; pixel_start = 1;
    @(negedge clk); pixel_start = 0;
    @(negedge clk); pixel_start = 1; pix_x = 10'd100; pix_y = 10'd105;
    @(negedge clk); pixel_start = 0;
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    check("ovr_drain", 64'(busy), 64'd0);
    check("ovr_set", 64'(overrun), 64'd1);
    pixel("ovr_next", 50, 50, 6, 12'h123, 0);
    check("ovr_sticky", 64'(overrun), 64'd1);

    // Reset mid-scan: outputs clear at once, no pulse, next request normal.
    rom_tbl[1] = 12'hABC;
    cfg(0, 96, 96, 1);
    pix_x = 10'd100; pix_y = 10'd105; pixel_start = 1;
    @(negedge clk); pixel_start = 0;
    @(negedge clk);
    #1 reset = 1;
    #1 check("reset_mid", {busy, pixel_valid, rom_index, rom_row, rom_col, rgb_out, overrun}, 64'd0);
    @(negedge clk);
    #1 reset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_nopulse", 64'(pixel_valid), 64'd0);
    end
    pixel("post_reset", 100, 105, 6, 12'h123, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/object_render_scheduler.md
Name: object_render_scheduler

Overview:
- Per-pixel sequencer and arbiter for the shared object sprite ROM port (row/col/index in, 12-bit color out, 1-cycle read latency).
- Holds position and enable registers for 4 object slots and tests which objects cover the requested pixel.
- Issues one ROM read per covering slot in priority order and returns the composited pixel color, or the background color, to the VGA pixel pipeline.

Parameters:
- NUM_SLOTS, 4, object slots; slot s reads ROM index s+1; slot 0 has highest priority.
- OBJ_W, 32, object width in pixels.
- OBJ_H, 32, object height in pixels.
- TRANSPARENT, 12'hF0F, ROM color treated as see-through.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_we  in  1  slot register write strobe
- cfg_slot  in  2  slot being written
- cfg_x  in  10  object left column
- cfg_y  in  10  object top row
- cfg_en  in  1  slot enable
- pixel_start  in  1  request compositing of (pix_x, pix_y)
- pix_x  in  10  requested column
- pix_y  in  10  requested row
- bg_color  in  12  color used when no object is opaque
- busy  out  1  scan in progress; requests are not accepted
- pixel_valid  out  1  1-cycle pulse; rgb_out is new
- rgb_out  out  12  composited color, held until the next pixel_valid
- overrun  out  1  sticky; a pixel_start arrived while busy
- rom_row  out  10  row offset to the ROM reader
- rom_col  out  10  column offset to the ROM reader
- rom_index  out  3  ROM select, 1..4; 0 = no read
- rom_data  in  12  ROM color, valid 1 cycle after the read is issued

Behaviour:
- Reset (asynchronous, on any edge) clears every register: all slots disabled with x = y = 0, state IDLE, busy 0, pixel_valid 0, rgb_out 0, overrun 0, rom_index 0, rom_row 0, rom_col 0. Reset asserted mid-scan aborts the scan and no pixel_valid is produced.
- Config write: cfg_we at an edge updates slot cfg_slot (x, y, en) on that edge, in any state. The scan runs on a snapshot of all slots taken when the request is accepted, so a write during busy affects only later pixels.
- Accept: in IDLE, pixel_start latches pix_x, pix_y and the slot snapshot, then moves to ISSUE with s = 0. pixel_start while busy is dropped and sets overrun.
- Hit test: 11-bit unsigned arithmetic, so there is no wrap. Slot hits if en && x <= px < x+OBJ_W && y <= py < y+OBJ_H.
- ISSUE(s), one cycle per slot:
  - If slot s hits: rom_index = s+1, rom_row = py-y, rom_col = px-x, pending set.
  - Otherwise: rom_index = 0, rom_row = rom_col = 0, no pending.
  - After s = NUM_SLOTS-1, go to WAIT.
- Evaluate, in the cycle after each issued read (ISSUE(s+1) or WAIT): if rom_data != TRANSPARENT, the winner is rom_data and the next state is DONE. A read still in flight is discarded and its data ignored.
- WAIT: one cycle to evaluate slot NUM_SLOTS-1, then DONE.
- DONE: one cycle.
  - rgb_out <= winner if one exists, else bg_color; pixel_valid = 1.
  - Then IDLE, and busy drops in the next cycle.
- Latency, counted in cycles after the accept edge:
  - worst case, no opaque hit: DONE in cycle 6;
  - slot 0 opaque: DONE in cycle 3.
- busy = (state != IDLE). The source must space pixel_start at least 7 clocks apart for worst case; with 4-clock spacing, overrun flags a violation.
- rom_index is 0 in IDLE, WAIT and DONE.

Test Plan:
- Reset: pulse reset mid-scan -> all outputs 0 immediately, no pixel_valid, next pixel_start accepted normally.
- No objects enabled; start (100,100), bg_color 12'h123 -> rom_index stays 0, pixel_valid in cycle 6, rgb_out 12'h123.
- Slot 0 at (96,96) enabled, rom_data 12'hABC; start (100,105) -> rom_index 1, row 9, col 4 in cycle 1; pixel_valid in cycle 3, rgb_out 12'hABC.
- Slots 0 and 2 overlap at the same pixel; slot 0 returns 12'hF0F and slot 2 returns 12'h0F0 -> reads index 1 (cycle 1) and index 3 (cycle 3); pixel_valid in cycle 5, rgb_out 12'h0F0.
- Boundaries, slot 1 at (608,448): pixel (639,479) -> hit with row 31, col 31; pixel (640,448) -> miss. Slot at x = 1000: start (1023,...) -> no wrap hit beyond 1031.
- Overrun and config: pixel_start in cycle 2 of a scan -> ignored, overrun 1 until reset. cfg_we disabling slot 0 during its scan -> current pixel still uses slot 0; the next pixel does not.
